// File: rtl/ifft_frame_ctrl_if.sv
// Stream and core-bus signals of the IFFT frame sequencer.
// master is the controller's view; slave is the surrounding source/core/sink view.
interface ifft_frame_ctrl_if;
  logic         s_valid;
  logic         s_ready;
  logic [31:0]  s_real;
  logic [31:0]  s_imag;
  logic         s_last;

  logic         core_rst;
  logic [255:0] core_xr;
  logic [255:0] core_xi;
  logic [255:0] core_yr;
  logic [255:0] core_yi;
  logic         core_done;

  logic         m_valid;
  logic         m_ready;
  logic [31:0]  m_real;
  logic [31:0]  m_imag;
  logic         m_last;

  modport master (
    input  s_valid, s_real, s_imag, s_last,
    input  core_yr, core_yi, core_done,
    input  m_ready,
    output s_ready, core_rst, core_xr, core_xi,
    output m_valid, m_real, m_imag, m_last
  );

  modport slave (
    output s_valid, s_real, s_imag, s_last,
    output core_yr, core_yi, core_done,
    output m_ready,
    input  s_ready, core_rst, core_xr, core_xi,
    input  m_valid, m_real, m_imag, m_last
  );
endinterface

// File: rtl/ifft_frame_ctrl.sv
// Frame sequencer for the 8-point IFFT core: serial load, core run, serial replay.
// Optional WAIT watchdog enabled by defining IFFT_CTRL_WATCHDOG_EN.
module ifft_frame_ctrl #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  ifft_frame_ctrl_if.master bus,
  output logic              err_frame,
  output logic              err_timeout,
  output logic [15:0]       frame_cnt,
  output logic              busy
);

  if (TIMEOUT < 8) begin : g_timeout_check
    $error("ifft_frame_ctrl: TIMEOUT must be at least 8");
  end

  typedef enum logic [1:0] {
    ST_LOAD,
    ST_RUN,
    ST_WAIT,
    ST_DRAIN
  } state_e;

  state_e             state_q, state_d;
  logic [2:0]         idx_q, idx_d;
  logic [2:0]         odx_q, odx_d;
  logic [7:0][31:0]   inr_q, ini_q;
  logic [7:0][31:0]   outr_q, outi_q;
  logic [15:0]        frame_cnt_q, frame_cnt_d;
  logic               err_frame_q, err_frame_d;
  logic               s_ready_q, s_ready_d;
  logic               in_we;
  logic               out_we;

`ifdef IFFT_CTRL_WATCHDOG_EN
  localparam int unsigned WDW = $clog2(TIMEOUT + 1);
  logic [WDW-1:0]     wdog_q, wdog_d;
  logic               err_timeout_q, err_timeout_d;
`endif

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    odx_d       = odx_q;
    frame_cnt_d = frame_cnt_q;
    err_frame_d = 1'b0;
    in_we       = 1'b0;
    out_we      = 1'b0;
`ifdef IFFT_CTRL_WATCHDOG_EN
    wdog_d        = wdog_q;
    err_timeout_d = err_timeout_q;
`endif
    unique case (state_q)
      ST_LOAD: begin
        // s_ready_q rather than the state is used so nothing is accepted in the cycle after reset
        if (bus.s_valid && s_ready_q) begin
          in_we = 1'b1;
          if (idx_q == 3'd7) begin
            idx_d       = '0;
            err_frame_d = ~bus.s_last;
            state_d     = ST_RUN;
          end else if (bus.s_last) begin
            idx_d       = '0;
            err_frame_d = 1'b1;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      ST_RUN: begin
`ifdef IFFT_CTRL_WATCHDOG_EN
        wdog_d = '0;
`endif
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (bus.core_done) begin
          out_we  = 1'b1;
          state_d = ST_DRAIN;
        end
`ifdef IFFT_CTRL_WATCHDOG_EN
        else begin
          wdog_d = wdog_q + 1'b1;
          if (wdog_q == WDW'(TIMEOUT - 1)) begin
            err_timeout_d = 1'b1;
            state_d       = ST_LOAD;
          end
        end
`endif
      end
      ST_DRAIN: begin
        if (bus.m_ready) begin
          if (odx_q == 3'd7) begin
            odx_d       = '0;
            frame_cnt_d = frame_cnt_q + 16'd1;
            state_d     = ST_LOAD;
          end else begin
            odx_d = odx_q + 3'd1;
          end
        end
      end
      default: state_d = ST_LOAD;
    endcase
    s_ready_d = (state_d == ST_LOAD);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_LOAD;
      idx_q       <= '0;
      odx_q       <= '0;
      inr_q       <= '0;
      ini_q       <= '0;
      outr_q      <= '0;
      outi_q      <= '0;
      frame_cnt_q <= '0;
      err_frame_q <= 1'b0;
      s_ready_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      odx_q       <= odx_d;
      frame_cnt_q <= frame_cnt_d;
      err_frame_q <= err_frame_d;
      s_ready_q   <= s_ready_d;
      if (in_we) begin
        inr_q[idx_q] <= bus.s_real;
        ini_q[idx_q] <= bus.s_imag;
      end
      if (out_we) begin
        outr_q <= bus.core_yr;
        outi_q <= bus.core_yi;
      end
    end
  end

`ifdef IFFT_CTRL_WATCHDOG_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wdog_q        <= '0;
      err_timeout_q <= 1'b0;
    end else begin
      wdog_q        <= wdog_d;
      err_timeout_q <= err_timeout_d;
    end
  end
  assign err_timeout = err_timeout_q;
`else
  assign err_timeout = 1'b0;
`endif

  assign bus.s_ready  = s_ready_q;
  assign bus.core_rst = (state_q == ST_LOAD) || (state_q == ST_DRAIN);
  assign bus.core_xr  = inr_q;
  assign bus.core_xi  = ini_q;
  assign bus.m_valid  = (state_q == ST_DRAIN);
  assign bus.m_real   = outr_q[odx_q];
  assign bus.m_imag   = outi_q[odx_q];
  assign bus.m_last   = (state_q == ST_DRAIN) && (odx_q == 3'd7);
  assign err_frame    = err_frame_q;
  assign frame_cnt    = frame_cnt_q;
  assign busy         = (state_q != ST_LOAD);

endmodule

// File: tb/tb_ifft_frame_ctrl.sv
// Self-checking bench for ifft_frame_ctrl with a behavioural 8-point core stand-in
// and a scoreboard of expected output samples.
module tb_ifft_frame_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        err_frame;
  logic        err_timeout;
  logic [15:0] frame_cnt;
  logic        busy;

  int unsigned checks   = 0;
  int unsigned failures = 0;
  logic [15:0] exp_cnt  = '0;
  logic        core_hang = 1'b0;
  int unsigned core_cnt = 0;

  typedef struct packed {
    logic [31:0] r;
    logic [31:0] i;
    logic        last;
  } exp_t;
  exp_t sbq[$];

  always #5 clk = ~clk;

  ifft_frame_ctrl_if bus ();

  ifft_frame_ctrl #(.TIMEOUT(15)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .err_frame  (err_frame),
    .err_timeout(err_timeout),
    .frame_cnt  (frame_cnt),
    .busy       (busy)
  );

  // Core stand-in: reverses bin order and adds k*0x100 on real, xors imag; done after 6 cycles.
  function automatic logic [255:0] core_fr(input logic [255:0] x);
    logic [255:0] y;
    for (int k = 0; k < 8; k++) y[32*k +: 32] = x[32*(7-k) +: 32] + 32'(k) * 32'h100;
    return y;
  endfunction

  function automatic logic [255:0] core_fi(input logic [255:0] x);
    logic [255:0] y;
    for (int k = 0; k < 8; k++) y[32*k +: 32] = x[32*k +: 32] ^ 32'hA5A5_0000;
    return y;
  endfunction

  always @(posedge clk) begin
    if (bus.core_rst) begin
      core_cnt      <= 0;
      bus.core_done <= 1'b0;
    end else begin
      core_cnt <= core_cnt + 1;
      if (core_cnt == 5 && !core_hang) begin
        bus.core_done <= 1'b1;
        bus.core_yr   <= core_fr(bus.core_xr);
        bus.core_yi   <= core_fi(bus.core_xi);
      end
    end
  end

  task automatic send_beat(input logic [31:0] r, input logic [31:0] im, input logic last);
    int unsigned n = 0;
    bus.s_valid = 1'b1;
    bus.s_real  = r;
    bus.s_imag  = im;
    bus.s_last  = last;
    while (!bus.s_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.s_ready) begin
      checks++; failures++;
      $display("FAIL send_beat_timeout s_ready=%0b required=1", bus.s_ready);
    end
    @(negedge clk);
  endtask

  task automatic push_frame(input logic [31:0] base_r, input logic [31:0] base_i,
                            input logic good_last, input logic expect_out);
    logic [31:0] vr[8];
    logic [31:0] vi[8];
    logic [255:0] xr;
    for (int k = 0; k < 8; k++) begin
      vr[k] = base_r + 32'(k);
      vi[k] = base_i * 32'(k + 1);
    end
    if (expect_out)
      for (int k = 0; k < 8; k++)
        sbq.push_back('{r: vr[7-k] + 32'(k) * 32'h100, i: vi[k] ^ 32'hA5A5_0000, last: (k == 7)});
    for (int k = 0; k < 8; k++) send_beat(vr[k], vi[k], (k == 7) ? good_last : 1'b0);
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
    xr = bus.core_xr;
    checks++;
    if (bus.core_rst !== 1'b0) begin
      failures++; $display("FAIL run_core_rst got=%0b exp=0", bus.core_rst);
    end
    checks++;
    if ({bus.s_ready, busy} !== 2'b01) begin
      failures++; $display("FAIL run_ready_busy got=%b exp=01", {bus.s_ready, busy});
    end
    checks++;
    if (err_frame !== !good_last) begin
      failures++; $display("FAIL frame_err_pulse got=%0b exp=%0b", err_frame, !good_last);
    end
    checks++;
    if (xr[31:0] !== vr[0] || xr[255:224] !== vr[7]) begin
      failures++;
      $display("FAIL core_xr_pack got=%h/%h exp=%h/%h", xr[31:0], xr[255:224], vr[0], vr[7]);
    end
  endtask

  task automatic collect(input logic [3:0] pat);
    int unsigned got = 0, guard = 0, p = 0;
    exp_t e;
    while (got < 8 && guard < 200) begin
      if (bus.m_valid) begin
        bus.m_ready = pat[p % 4];
        p++;
        if (sbq.size() == 0) begin
          checks++; failures++;
          $display("FAIL out_unexpected got=%h/%h exp=none", bus.m_real, bus.m_imag);
          break;
        end
        e = sbq[0];
        checks++;
        if ({bus.m_real, bus.m_imag, bus.m_last} !== {e.r, e.i, e.last}) begin
          failures++;
          $display("FAIL out_sample got=%h/%h/%0b exp=%h/%h/%0b",
                   bus.m_real, bus.m_imag, bus.m_last, e.r, e.i, e.last);
        end
        checks++;
        if (bus.s_ready !== 1'b0) begin
          failures++; $display("FAIL drain_s_ready got=%0b exp=0", bus.s_ready);
        end
        if (bus.m_ready) begin
          void'(sbq.pop_front());
          got++;
        end
      end else begin
        bus.m_ready = 1'b0;
      end
      @(negedge clk);
      guard++;
    end
    bus.m_ready = 1'b0;
    checks++;
    if (got != 8) begin
      failures++; $display("FAIL drain_timeout got=%0d exp=8", got);
    end
    exp_cnt = exp_cnt + 16'd1;
    checks++;
    if ({bus.m_valid, bus.s_ready, busy} !== 3'b010) begin
      failures++; $display("FAIL post_drain_state got=%b exp=010", {bus.m_valid, bus.s_ready, busy});
    end
    checks++;
    if (frame_cnt !== exp_cnt) begin
      failures++; $display("FAIL frame_cnt got=%h exp=%h", frame_cnt, exp_cnt);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    checks++;
    if ({bus.s_ready, bus.core_rst, bus.m_valid, bus.m_last, err_frame, err_timeout, busy} !== 7'b0100000) begin
      failures++;
      $display("FAIL %s_ctrl got=%b exp=0100000", tag,
               {bus.s_ready, bus.core_rst, bus.m_valid, bus.m_last, err_frame, err_timeout, busy});
    end
    checks++;
    if (frame_cnt !== 16'h0 || bus.core_xr !== '0 || bus.core_xi !== '0 ||
        bus.m_real !== 32'h0 || bus.m_imag !== 32'h0) begin
      failures++;
      $display("FAIL %s_data got=cnt %h xr0 %h mr %h exp=0", tag, frame_cnt, bus.core_xr[31:0], bus.m_real);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.s_ready !== 1'b1) begin
      failures++; $display("FAIL reset_release_s_ready got=%0b exp=1", bus.s_ready);
    end
  endtask

  task automatic test_single();
    push_frame(32'd1, 32'd0, 1'b1, 1'b1);
    collect(4'b1111);
  endtask

  task automatic test_early_last();
    send_beat(32'h77, 32'h1, 1'b0);
    send_beat(32'h78, 32'h2, 1'b0);
    send_beat(32'h79, 32'h3, 1'b1);
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
    checks++;
    if ({err_frame, busy} !== 2'b10) begin
      failures++; $display("FAIL early_last_pulse got=%b exp=10", {err_frame, busy});
    end
    @(negedge clk);
    checks++;
    if (err_frame !== 1'b0) begin
      failures++; $display("FAIL early_last_single got=%0b exp=0", err_frame);
    end
    push_frame(32'h1000, 32'h3, 1'b1, 1'b1);
    collect(4'b1111);
  endtask

  task automatic test_missing_last();
    push_frame(32'h2000, 32'h5, 1'b0, 1'b1);
    collect(4'b1111);
  endtask

  task automatic test_backpressure();
    push_frame(32'h3000_0000, 32'h11, 1'b1, 1'b1);
    collect(4'b1001);
  endtask

  task automatic test_back_to_back();
    push_frame(32'h4000, 32'h21, 1'b1, 1'b1);
    collect(4'b1111);
    push_frame(32'h5000, 32'h31, 1'b1, 1'b1);
    collect(4'b1011);
  endtask

  task automatic test_wrap();
    force dut.frame_cnt_q = 16'hFFFF;
    @(negedge clk);
    release dut.frame_cnt_q;
    @(negedge clk);
    exp_cnt = 16'hFFFF;
    checks++;
    if (frame_cnt !== 16'hFFFF) begin
      failures++; $display("FAIL wrap_preload got=%h exp=ffff", frame_cnt);
    end
    push_frame(32'h6000, 32'h41, 1'b1, 1'b1);
    collect(4'b1111);
  endtask

  task automatic test_watchdog();
    int unsigned low = 0, guard = 0;
    logic        saw_valid = 1'b0;
    core_hang = 1'b1;
    push_frame(32'h7000, 32'h51, 1'b1, 1'b0);
`ifdef IFFT_CTRL_WATCHDOG_EN
    low = 1;
    while (busy && guard < 100) begin
      @(negedge clk);
      guard++;
      if (bus.core_rst === 1'b0) low++;
      if (bus.m_valid) saw_valid = 1'b1;
    end
    checks++;
    if (low != 16) begin
      failures++; $display("FAIL wdog_cycles got=%0d exp=16", low);
    end
    checks++;
    if ({err_timeout, bus.core_rst, bus.s_ready, busy, saw_valid} !== 5'b11100) begin
      failures++;
      $display("FAIL wdog_state got=%b exp=11100", {err_timeout, bus.core_rst, bus.s_ready, busy, saw_valid});
    end
    checks++;
    if (frame_cnt !== exp_cnt) begin
      failures++; $display("FAIL wdog_frame_cnt got=%h exp=%h", frame_cnt, exp_cnt);
    end
    core_hang = 1'b0;
    push_frame(32'h8000, 32'h61, 1'b1, 1'b1);
    collect(4'b1111);
    checks++;
    if (err_timeout !== 1'b1) begin
      failures++; $display("FAIL wdog_sticky got=%0b exp=1", err_timeout);
    end
`else
    repeat (40) begin
      @(negedge clk);
      if (bus.m_valid) saw_valid = 1'b1;
      if (bus.core_rst === 1'b0) low++;
    end
    checks++;
    if ({busy, err_timeout, saw_valid} !== 3'b100 || low != 40) begin
      failures++;
      $display("FAIL nowdog_wait got=%b/%0d exp=100/40", {busy, err_timeout, saw_valid}, low);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp_cnt = '0;
    core_hang = 1'b0;
    @(negedge clk);
`endif
    core_hang = 1'b0;
  endtask

  task automatic test_mid_reset();
    push_frame(32'h9000, 32'h71, 1'b1, 1'b0);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({busy, bus.core_rst, bus.m_valid} !== 3'b100) begin
      failures++; $display("FAIL midrst_in_wait got=%b exp=100", {busy, bus.core_rst, bus.m_valid});
    end
    reset = 1'b1;
    #1;
    check_reset_vals("midrst");
    @(negedge clk);
    reset = 1'b0;
    exp_cnt = '0;
    @(negedge clk);
    push_frame(32'hA000, 32'h81, 1'b1, 1'b1);
    collect(4'b1111);
  endtask

  initial begin
    reset        = 1'b1;
    bus.s_valid  = 1'b0;
    bus.s_real   = '0;
    bus.s_imag   = '0;
    bus.s_last   = 1'b0;
    bus.m_ready  = 1'b0;
    test_reset();
    test_single();
    test_early_last();
    test_missing_last();
    test_backpressure();
    test_back_to_back();
    test_wrap();
    test_watchdog();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
